// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter and its counters.
package dmem_arb_pkg;

  localparam int          DMEM_AW       = 32;
  localparam int          DMEM_DW       = 32;
  localparam logic [31:0] DMEM_ERR_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_A = 2'd1,
    BUSY_B = 2'd2,
    ACK    = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating up-counter with synchronous clear; used both as the starvation
// guard for requester B and as the memory-ready timeout counter.
module dmem_arb_starve_ctr #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  input  logic         clr_i,
  input  logic [W-1:0] limit_i,
  output logic         at_limit_o,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear wins over increment; increment stops once the limit is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q < limit_i)) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q >= limit_i);
  assign cnt_o      = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: MEM stage (A, fixed priority) vs debug/DMA (B) with
// a starvation guard. Define DMEM_TIMEOUT_EN for the mem_ready timeout and bus_err.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = DMEM_AW,
  parameter int DW       = DMEM_DW,
  parameter int MAX_WAIT = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          a_read,
  input  logic          a_write,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic [DW-1:0] a_rdata,
  output logic          a_ack,
  output logic          a_stall,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic [DW-1:0] b_rdata,
  output logic          b_ack,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          bus_err
);

  arb_state_e    state_q, state_d;
  owner_e        owner_q, owner_d;
  logic          mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic          a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic          pa_s, busy_s, wait_inc_s, wait_clr_s, wait_at_lim_s, timeout_s;
  logic [3:0]    wait_cnt;

  assign pa_s   = a_read | a_write;
  assign busy_s = (state_q == BUSY_A) || (state_q == BUSY_B);

  dmem_arb_starve_ctr #(.W(4)) u_starve (
    .clk_i      (CLK),
    .rst_ni     (RESET),
    .inc_i      (wait_inc_s),
    .clr_i      (wait_clr_s),
    .limit_i    (4'(MAX_WAIT)),
    .at_limit_o (wait_at_lim_s),
    .cnt_o      (wait_cnt)
  );

`ifdef DMEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic          to_at_lim_s;
  logic [TW-1:0] to_cnt_s;
  logic          bus_err_q;

  // Counts BUSY cycles without mem_ready; cleared outside BUSY so each access starts at 0.
  dmem_arb_starve_ctr #(.W(TW)) u_timeout (
    .clk_i      (CLK),
    .rst_ni     (RESET),
    .inc_i      (busy_s & ~mem_ready),
    .clr_i      (~busy_s),
    .limit_i    (TW'(TIMEOUT - 1)),
    .at_limit_o (to_at_lim_s),
    .cnt_o      (to_cnt_s)
  );

  assign timeout_s = busy_s & ~mem_ready & to_at_lim_s;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= bus_err_q | timeout_s;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign timeout_s = 1'b0;
  assign bus_err   = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    wait_inc_s  = 1'b0;
    wait_clr_s  = 1'b0;
    case (state_q)
      IDLE: begin
        // A store wins over a simultaneous load from the same stage.
        if (b_req && (wait_at_lim_s || !pa_s)) begin
          state_d     = BUSY_B;
          owner_d     = OWN_B;
          mem_read_d  = ~b_we;
          mem_write_d = b_we;
          mem_addr_d  = b_addr;
          mem_wdata_d = b_wdata;
          wait_clr_s  = 1'b1;
        end else if (pa_s) begin
          state_d     = BUSY_A;
          owner_d     = OWN_A;
          mem_read_d  = a_read & ~a_write;
          mem_write_d = a_write;
          mem_addr_d  = a_addr;
          mem_wdata_d = a_wdata;
          wait_inc_s  = b_req;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY_A, BUSY_B: begin
        if (mem_ready || timeout_s) begin
          state_d     = ACK;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (owner_q == OWN_A) begin
            a_rdata_d = mem_ready ? mem_rdata : DW'(DMEM_ERR_DATA);
            a_ack_d   = 1'b1;
          end else begin
            b_rdata_d = mem_ready ? mem_rdata : DW'(DMEM_ERR_DATA);
            b_ack_d   = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      owner_q     <= OWN_A;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;
  assign a_stall   = pa_s & ~a_ack_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: per-cycle reference model plus directed
// scenarios with hand-computed expectations.
module tb_dmem_arbiter;

  localparam int MAX_WAIT = 4;
  localparam int TIMEOUT  = 16;
`ifdef DMEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        CLK = 1'b0, RESET = 1'b0;
  logic        a_read = 1'b0, a_write = 1'b0;
  logic [31:0] a_addr = '0, a_wdata = '0, a_rdata;
  logic        a_ack, a_stall;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [31:0] b_addr = '0, b_wdata = '0, b_rdata;
  logic        b_ack;
  logic        mem_read, mem_write, mem_ready = 1'b0, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0, a_ack_cnt = 0;
  int          resp_delay = 0, busy_n = 0;
  logic [31:0] resp_base = '0;

  dmem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RESET(RESET),
    .a_read(a_read), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_ack(a_ack), .a_stall(a_stall),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_ack(b_ack),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .bus_err(bus_err)
  );

  always #5 CLK = ~CLK;

  // Memory returns a value derived from the address so each access is distinguishable.
  assign mem_rdata = resp_base ^ mem_addr;

  initial forever begin
    @(posedge CLK); #1;
    if (mem_read | mem_write) begin
      mem_ready = (busy_n == resp_delay);
      busy_n    = busy_n + 1;
    end else begin
      mem_ready = 1'b0;
      busy_n    = 0;
    end
  end

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (a_ack) a_ack_cnt <= a_ack_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: who owns the port (0 none, 1 A, 2 B), who is being acked,
  // B's loss count and the elapsed BUSY cycles of the current access.
  int          m_own = 0, m_ackw = 0, m_wait = 0, m_tcnt = 0;
  logic        m_err = 1'b0, e_rd = 1'b0, e_wr = 1'b0;
  logic [31:0] e_addr = '0, e_wdata = '0, e_ardata = '0, e_brdata = '0;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      m_own <= 0; m_ackw <= 0; m_wait <= 0; m_tcnt <= 0; m_err <= 1'b0;
      e_rd <= 1'b0; e_wr <= 1'b0; e_addr <= '0; e_wdata <= '0;
      e_ardata <= '0; e_brdata <= '0;
    end else if (m_ackw != 0) begin
      m_ackw <= 0;
    end else if (m_own != 0) begin
      if (mem_ready || (TO_EN && (m_tcnt + 1 == TIMEOUT))) begin
        if (m_own == 1) e_ardata <= mem_ready ? mem_rdata : 32'hDEADBEEF;
        else            e_brdata <= mem_ready ? mem_rdata : 32'hDEADBEEF;
        m_err  <= m_err | !mem_ready;
        m_ackw <= m_own;
        m_own  <= 0;
        e_rd   <= 1'b0;
        e_wr   <= 1'b0;
      end else begin
        m_tcnt <= m_tcnt + 1;
      end
    end else if (b_req && ((m_wait == MAX_WAIT) || !(a_read || a_write))) begin
      m_own <= 2; m_wait <= 0; m_tcnt <= 0;
      e_rd <= !b_we; e_wr <= b_we; e_addr <= b_addr; e_wdata <= b_wdata;
    end else if (a_read || a_write) begin
      m_own <= 1; m_tcnt <= 0;
      if (b_req) m_wait <= (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
      e_rd <= a_read && !a_write; e_wr <= a_write; e_addr <= a_addr; e_wdata <= a_wdata;
    end
  end

  always @(negedge CLK) begin
    chk("mem_read", 32'(mem_read), 32'(e_rd));
    chk("mem_write", 32'(mem_write), 32'(e_wr));
    chk("a_ack", 32'(a_ack), 32'(m_ackw == 1));
    chk("b_ack", 32'(b_ack), 32'(m_ackw == 2));
    chk("a_stall", 32'(a_stall), 32'((a_read | a_write) && (m_ackw != 1)));
    chk("bus_err", 32'(bus_err), 32'(m_err));
    chk("wait_cnt", 32'(dut.wait_cnt), 32'(m_wait));
    if (e_rd || e_wr || !RESET) begin
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
    end
    if (m_ackw == 1 || !RESET) chk("a_rdata", a_rdata, e_ardata);
    if (m_ackw == 2 || !RESET) chk("b_rdata", b_rdata, e_brdata);
  end

  task automatic next();
    @(posedge CLK); #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic wait_ack(input bit is_b, input string nm);
    int k;
    k = 0;
    sample();
    while (((is_b ? b_ack : a_ack) !== 1'b1) && (k < 40)) begin
      next();
      sample();
      k++;
    end
    n_cmp = n_cmp + 1;
    if (k >= 40) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: no ack within 40 cycles", nm);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_a, t_b, ack0, t0;
    repeat (2) @(posedge CLK);
    sample();
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_a_ack", 32'(a_ack), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    next(); RESET = 1'b1;

    // Single A load, fastest memory.
    next(); resp_base = 32'h12345778; resp_delay = 0; a_read = 1'b1; a_addr = 32'h100;
    sample(); chk("t1_stall_c0", 32'(a_stall), 32'd1); chk("t1_rd_c0", 32'(mem_read), 32'd0);
    next(); sample();
    chk("t1_rd_c1", 32'(mem_read), 32'd1); chk("t1_addr_c1", mem_addr, 32'h100);
    chk("t1_stall_c1", 32'(a_stall), 32'd1);
    next(); sample();
    chk("t1_ack_c2", 32'(a_ack), 32'd1); chk("t1_rdata_c2", a_rdata, 32'h12345678);
    chk("t1_stall_c2", 32'(a_stall), 32'd0);
    next(); a_read = 1'b0;

    // A and B together, slow memory: A first, then B.
    next(); resp_base = 32'h0BAD0000; resp_delay = 3;
    a_read = 1'b1; a_addr = 32'h200; b_req = 1'b1; b_we = 1'b0; b_addr = 32'h300;
    next(); sample();
    chk("t2_wait_after_a", 32'(dut.wait_cnt), 32'd1); chk("t2_addr_a", mem_addr, 32'h200);
    wait_ack(1'b0, "t2_a"); t_a = cyc; chk("t2_a_rdata", a_rdata, 32'h0BAD0200);
    next(); a_read = 1'b0;
    wait_ack(1'b1, "t2_b"); t_b = cyc; chk("t2_b_rdata", b_rdata, 32'h0BAD0300);
    chk("t2_gap", 32'(t_b - t_a), 32'd6);
    next(); b_req = 1'b0;

    // Five back-to-back A stores against a pending B write.
    next(); resp_delay = 1; resp_base = '0;
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'h80; b_wdata = 32'h11112222; ack0 = a_ack_cnt;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          a_write = 1'b1; a_addr = 32'h1000 + 32'(i * 4); a_wdata = 32'(i);
          wait_ack(1'b0, "t3_a");
          next();
        end
        a_write = 1'b0;
      end
      begin
        wait_ack(1'b1, "t3_b");
        chk("t3_a_before_b", 32'(a_ack_cnt - ack0), 32'd4);
        chk("t3_wait_clr", 32'(dut.wait_cnt), 32'd0);
        next(); b_req = 1'b0;
      end
    join

    // B write, ready on the second BUSY cycle.
    next(); resp_delay = 1; b_req = 1'b1; b_we = 1'b1; b_addr = 32'h40; b_wdata = 32'hCAFEF00D;
    sample(); chk("t4_stall_c0", 32'(a_stall), 32'd0);
    next(); sample();
    chk("t4_wr_c1", 32'(mem_write), 32'd1); chk("t4_wdata_c1", mem_wdata, 32'hCAFEF00D);
    chk("t4_stall_c1", 32'(a_stall), 32'd0);
    next(); sample();
    chk("t4_wr_c2", 32'(mem_write), 32'd1); chk("t4_addr_c2", mem_addr, 32'h40);
    next(); sample();
    chk("t4_back_c3", 32'(b_ack), 32'd1); chk("t4_wr_c3", 32'(mem_write), 32'd0);
    next(); b_req = 1'b0; sample(); chk("t4_back_c4", 32'(b_ack), 32'd0);

    // Load and store asserted together is a store.
    next(); resp_delay = 0; a_read = 1'b1; a_write = 1'b1; a_addr = 32'h44; a_wdata = 32'h55AA55AA;
    next(); sample();
    chk("t5_wr", 32'(mem_write), 32'd1); chk("t5_rd", 32'(mem_read), 32'd0);
    chk("t5_wdata", mem_wdata, 32'h55AA55AA);
    wait_ack(1'b0, "t5_a");
    next(); a_read = 1'b0; a_write = 1'b0;

    // Reset in the middle of an A access.
    next(); resp_delay = 1000; a_read = 1'b1; a_addr = 32'h180;
    next(); sample(); chk("t6_rd_busy", 32'(mem_read), 32'd1);
    next(); RESET = 1'b0; a_read = 1'b0; #1;
    chk("t6_rst_rd", 32'(mem_read), 32'd0); chk("t6_rst_addr", mem_addr, 32'd0);
    chk("t6_rst_rdata", a_rdata, 32'd0); chk("t6_rst_ack", 32'(a_ack), 32'd0);
    next(); RESET = 1'b1; resp_delay = 0; ack0 = a_ack_cnt;
    repeat (4) next();
    sample(); chk("t6_no_ack", 32'(a_ack_cnt - ack0), 32'd0);

`ifdef DMEM_TIMEOUT_EN
    // Memory never answers: the access is aborted with the error pattern.
    next(); resp_delay = 1000; a_read = 1'b1; a_addr = 32'h1C0; t0 = cyc;
    wait_ack(1'b0, "t7_a");
    chk("t7_latency", 32'(cyc - t0), 32'd17);
    chk("t7_rdata", a_rdata, 32'hDEADBEEF); chk("t7_err", 32'(bus_err), 32'd1);
    next(); a_read = 1'b0; resp_delay = 0;
    repeat (3) next();
    sample(); chk("t7_err_sticky", 32'(bus_err), 32'd1);
`else
    t0 = 0;
    next(); sample(); chk("t7_err_off", 32'(bus_err), 32'd0);
`endif

    repeat (2) next();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
